// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the async FIFO read-side blocks.
package async_fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned RATIO_DEF = 4;

    // Width of a lane counter that wraps from ratio-1 back to 0.
    function automatic int unsigned lane_cnt_w(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/packer_timeout_ctr.sv
// Idle-cycle counter for the read packer: raises hit once a partial beat has
// waited TIMEOUT cycles without a pop. Used only with FIFO_RD_PACKER_TIMEOUT_EN.
module packer_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic active,
    input  logic pop,
    input  logic flush,
    output logic hit
);

    logic [7:0] idle;

    // Saturates at TIMEOUT so a stalled flush keeps hit asserted.
    always_ff @(posedge rclk) begin
        if (rrst || pop || flush || !active)
            idle <= '0;
        else if (!hit)
            idle <= idle + 8'd1;
    end

    assign hit = (idle >= 8'(TIMEOUT));

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs RATIO fall-through FIFO words into one output beat, lane 0 oldest.
// Define FIFO_RD_PACKER_TIMEOUT_EN to flush partial beats after TIMEOUT idle cycles.
module fifo_rd_packer
    import async_fifo_pkg::*;
#(
    parameter int unsigned DSIZE   = DSIZE_DEF,
    parameter int unsigned RATIO   = RATIO_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    output logic                   rinc,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DSIZE*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_mask
);

    localparam int unsigned   CW   = lane_cnt_w(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if (RATIO < 2 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("fifo_rd_packer: RATIO must be a power of two in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fifo_rd_packer: TIMEOUT must be in 1..255");
    end

    logic [CW-1:0]                 cnt;
    logic [RATIO-1:0][DSIZE-1:0]   acc;
    logic [RATIO-1:0][DSIZE-1:0]   beat;
    logic                          can_accept, pop, last_pop, flush, load;
    logic [RATIO-1:0]              load_mask;

    // Only the final lane waits on the output register; earlier lanes keep filling.
    assign can_accept = (cnt != LAST) || !out_valid || out_ready;
    assign rinc       = !rempty && !rrst && can_accept;
    assign pop        = rinc;
    assign last_pop   = pop && (cnt == LAST);

    always_comb begin
        beat      = acc;
        beat[cnt] = rdata;
    end

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic             idle_hit;
    logic [RATIO-1:0] fill_mask;

    packer_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_idle (
        .rclk   (rclk),
        .rrst   (rrst),
        .active (cnt != '0),
        .pop    (pop),
        .flush  (flush),
        .hit    (idle_hit)
    );

    assign flush = idle_hit && (cnt != '0) && !pop && (!out_valid || out_ready);

    always_comb begin
        fill_mask = '0;
        for (int i = 0; i < RATIO; i++)
            fill_mask[i] = (CW'(i) < cnt);
    end

    assign load_mask = flush ? fill_mask : '1;
`else
    assign flush     = 1'b0;
    assign load_mask = '1;
`endif

    assign load = last_pop || flush;

    // acc is cleared on every load so a flushed beat carries zeros in unfilled lanes.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (load) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b1;
            out_data  <= flush ? acc : beat;
            out_mask  <= load_mask;
        end else begin
            if (pop) begin
                acc <= beat;
                cnt <= cnt + 1'b1;
            end
            if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a source FIFO model feeds words, a packing
// reference model predicts beats, and a negedge monitor compares them.
module tb_fifo_rd_packer;

    localparam int DSIZE   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int DW      = DSIZE * RATIO;

    typedef struct {
        logic [DW-1:0]    data;
        logic [RATIO-1:0] mask;
    } beat_t;

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic             rinc;
    logic [DSIZE-1:0] rdata = '0;
    logic             rempty = 1'b1;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic [RATIO-1:0] out_mask;

    beat_t            exp_q[$];
    logic [DSIZE-1:0] src_q[$];
    logic [DSIZE-1:0] part[$];

    int total = 0, bad = 0, beats = 0, idle = 0, ready_mode = 0;
    bit gap_en = 0, pop_now = 0, lat_chk = 0, done_prev = 0;
    logic [DW-1:0]    last_data = '0;
    logic [RATIO-1:0] last_mask = '0;

    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rinc      (rinc),
        .rdata     (rdata),
        .rempty    (rempty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference packing: words in pop order, lane 0 first, unfilled lanes zero.
    function automatic beat_t pack_part();
        beat_t b;
        b.data = '0;
        b.mask = '0;
        for (int i = 0; i < part.size(); i++) begin
            b.data[i*DSIZE +: DSIZE] = part[i];
            b.mask[i] = 1'b1;
        end
        return b;
    endfunction

    // Monitor: inputs are stable at negedge, so these are the values the next edge sees.
    always @(negedge rclk) begin
        beat_t e;
        bit    done;
        pop_now = rinc;
        chk("no_underflow", rinc && rempty, 0);
        if (rrst) begin
            part.delete();
            exp_q.delete();
            idle      = 0;
            done_prev = 0;
        end else begin
            done = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_mask", out_mask, e.mask);
                    last_data = out_data;
                    last_mask = out_mask;
                    beats++;
                end
            end
            if (rinc) begin
                part.push_back(rdata);
                idle = 0;
                if (part.size() == RATIO) begin
                    exp_q.push_back(pack_part());
                    part.delete();
                    done = 1;
                end
            end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            else if (part.size() > 0) begin
                if (idle >= TIMEOUT && (!out_valid || out_ready)) begin
                    exp_q.push_back(pack_part());
                    part.delete();
                    idle = 0;
                end else begin
                    idle++;
                end
            end
`endif
            if (lat_chk) chk("latency", out_valid, done_prev);
            done_prev = done;
        end
    end

    // Source FIFO and downstream ready driver.
    initial forever begin
        @(posedge rclk);
        #1;
        if (pop_now && src_q.size() > 0) void'(src_q.pop_front());
        rempty = (src_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
        rdata  = (src_q.size() > 0) ? src_q[0] : DSIZE'($urandom);
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge rclk);
    endtask

    task automatic drain(input string name, input int maxc);
        int k = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || out_valid) && k < maxc) begin
            @(posedge rclk);
            k++;
        end
        total++;
        if (k >= maxc) begin
            bad++;
            $display("FAIL %s_drain: got %0d words %0d beats pending want 0", name, src_q.size(), exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rrst = 1'b1;
        ready_mode = 0;
        cycles(2);
        @(negedge rclk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_mask", out_mask, 0);
        chk("rst_rinc", rinc, 0);
        @(posedge rclk);
        #2 rrst = 1'b0;

        // Full beats, ready high, one-cycle latency after the completing pop.
        ready_mode = 1;
        lat_chk    = 1;
        b0 = beats;
        for (int i = 1; i <= 8; i++) src_q.push_back(DSIZE'(i));
        drain("full", 100);
        lat_chk = 0;
        chk("full_beats", beats - b0, 2);
        chk("full_last", last_data, 32'h08070605);
        chk("full_mask", last_mask, 4'hF);

        // Empty source: never pop, never present a beat.
        repeat (30) begin
            @(negedge rclk);
            chk("empty_rinc", rinc, 0);
            chk("empty_valid", out_valid, 0);
        end

        // Stalled output: one beat held, three lanes filled, final lane waits.
        ready_mode = 0;
        b0 = beats;
        for (int i = 0; i < 8; i++) src_q.push_back(DSIZE'(8'h21 + i));
        cycles(20);
        @(negedge rclk);
        chk("stall_rinc", rinc, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_left", src_q.size(), 1);
        chk("stall_data", out_data, 32'h24232221);
        ready_mode = 1;
        drain("stall", 100);
        chk("stall_beats", beats - b0, 2);
        chk("stall_last", last_data, 32'h28272625);

        // Reset after a partial beat: it is dropped and lanes restart at 0.
        b0 = beats;
        for (int i = 0; i < 3; i++) src_q.push_back(DSIZE'(8'h31 + i));
        drain("part", 50);
        @(posedge rclk);
        #2 rrst = 1'b1;
        @(posedge rclk);
        #2 rrst = 1'b0;
        for (int i = 0; i < 4; i++) src_q.push_back(DSIZE'(8'h41 + i));
        drain("rst", 50);
        chk("rst_beats", beats - b0, 1);
        chk("rst_last", last_data, 32'h44434241);

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        // Partial beat flushed after the idle timeout.
        b0 = beats;
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        cycles(TIMEOUT + 10);
        chk("flush_beats", beats - b0, 1);
        chk("flush_data", last_data, 32'h0000BBAA);
        chk("flush_mask", last_mask, 4'h3);
`endif

        // Random words with toggling, then random, ready and source gaps.
        gap_en = 1;
        ready_mode = 2;
        b0 = beats;
        for (int i = 0; i < 200; i++) src_q.push_back(DSIZE'($urandom));
        drain("toggle", 3000);
        chk("toggle_beats", beats - b0, 50);
        ready_mode = 3;
        b0 = beats;
        for (int i = 0; i < 200; i++) src_q.push_back(DSIZE'($urandom));
        drain("random", 3000);
        chk("random_beats", beats - b0, 50);
        gap_en = 0;

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
